// File: rtl/spi_sd_pkg.sv
// Shared constants for the SD-card SPI link: FSM encoding, frame lengths and timing defaults.
package spi_sd_pkg;

  localparam int unsigned DATA_W        = 40;
  localparam int unsigned R1_BITS       = 8;
  localparam int unsigned R7_BITS       = 40;
  localparam int unsigned DEF_RESP_BITS = R1_BITS;
  localparam int unsigned DEF_TIMEOUT   = 8;
  localparam int unsigned DEF_WAIT      = 10;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_HUNT  = 3'd1;
  localparam logic [2:0] ST_SHIFT = 3'd2;
  localparam logic [2:0] ST_GAP   = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Counter width able to hold 0..lim-1, never narrower than one bit
  function automatic int unsigned cnt_w(input int unsigned lim);
    return (lim > 1) ? $clog2(lim) : 1;
  endfunction

endpackage

// File: rtl/spi_resp_rx.sv
// SPI response receiver: hunts MISO for the start bit, shifts in a fixed-length
// response MSB-first, holds CS high for an inter-frame gap, then pulses done.
module spi_resp_rx
  import spi_sd_pkg::*;
#(
  parameter int unsigned RESP_BITS = DEF_RESP_BITS,
  parameter int unsigned TIMEOUT   = DEF_TIMEOUT,
  parameter int unsigned WAIT      = DEF_WAIT
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_miso,
  output logic              o_cs,
  output logic [DATA_W-1:0] o_data,
  output logic              o_timeout,
  output logic              o_done
);

  // One counter serves both hunt and bit counting, so size it for the larger limit
  localparam int unsigned CNT_W = cnt_w((TIMEOUT > RESP_BITS) ? TIMEOUT : RESP_BITS);
  localparam int unsigned GAP_W = cnt_w(WAIT);

  logic [2:0]           state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [GAP_W-1:0]     gap_q, gap_d;
  logic [RESP_BITS-1:0] sreg_q, sreg_d;
  logic                 cs_d, tmo_d, done_d;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      gap_q     <= '0;
      sreg_q    <= '0;
      o_cs      <= 1'b1;
      o_timeout <= 1'b0;
      o_done    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      gap_q     <= gap_d;
      sreg_q    <= sreg_d;
      o_cs      <= cs_d;
      o_timeout <= tmo_d;
      o_done    <= done_d;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    sreg_d  = sreg_q;
    cs_d    = o_cs;
    tmo_d   = o_timeout;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cs_d = 1'b1;
        if (i_start) begin
          cs_d    = 1'b0;
          sreg_d  = '0;
          tmo_d   = 1'b0;
          cnt_d   = '0;
          gap_d   = '0;
          state_d = ST_HUNT;
        end
      end

      ST_HUNT: begin
        if (!i_miso) begin
          sreg_d  = {sreg_q[RESP_BITS-2:0], 1'b0};
          cnt_d   = CNT_W'(1);
          state_d = ST_SHIFT;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          sreg_d  = '1;
          tmo_d   = 1'b1;
          cs_d    = 1'b1;
          gap_d   = '0;
          state_d = ST_GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_SHIFT: begin
        sreg_d = {sreg_q[RESP_BITS-2:0], i_miso};
        if (cnt_q == CNT_W'(RESP_BITS - 1)) begin
          cs_d    = 1'b1;
          gap_d   = '0;
          state_d = ST_GAP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_GAP: begin
        if (gap_q == GAP_W'(WAIT - 1)) begin
          state_d = ST_DONE;
        end else begin
          gap_d = gap_q + GAP_W'(1);
        end
      end

      ST_DONE: begin
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end

      default: begin
        cs_d    = 1'b1;
        state_d = ST_IDLE;
      end
    endcase
  end

  assign o_data = DATA_W'(sreg_q);

endmodule
